// File: rtl/pi_alu_sequencer_if.sv
// pi_alu_sequencer_if
// Bundles the sequencer's handshake and ALU-facing signals.
//   master : the sequencer (drives A2D request, ALU selects/flags, result registers, done)
//   slave  : the environment (drives go, A2D response, ALU dst)
// Signals:
//   go, a2d_req, a2d_chnl[2:0], a2d_vld, a2d_res[11:0], dst[15:0],
//   src1sel[2:0], src0sel[2:0], multiply, sub, mult2, mult4, saturate,
//   accum[15:0], pcomp[15:0], error/intgrl/icomp/rht/lft[11:0], done
// Optional: INTGRL_CLR_EN adds intgrl_clr (environment -> sequencer).

interface pi_alu_sequencer_if;
  logic        go;
  logic        a2d_req;
  logic [2:0]  a2d_chnl;
  logic        a2d_vld;
  logic [11:0] a2d_res;
  logic [15:0] dst;
  logic [2:0]  src1sel;
  logic [2:0]  src0sel;
  logic        multiply;
  logic        sub;
  logic        mult2;
  logic        mult4;
  logic        saturate;
  logic [15:0] accum;
  logic [15:0] pcomp;
  logic [11:0] error;
  logic [11:0] intgrl;
  logic [11:0] icomp;
  logic [11:0] rht;
  logic [11:0] lft;
  logic        done;
`ifdef INTGRL_CLR_EN
  logic        intgrl_clr;
`endif

  modport master (
`ifdef INTGRL_CLR_EN
    input  intgrl_clr,
`endif
    input  go, a2d_vld, a2d_res, dst,
    output a2d_req, a2d_chnl, src1sel, src0sel, multiply, sub, mult2, mult4, saturate,
    output accum, pcomp, error, intgrl, icomp, rht, lft, done
  );

  modport slave (
`ifdef INTGRL_CLR_EN
    output intgrl_clr,
`endif
    output go, a2d_vld, a2d_res, dst,
    input  a2d_req, a2d_chnl, src1sel, src0sel, multiply, sub, mult2, mult4, saturate,
    input  accum, pcomp, error, intgrl, icomp, rht, lft, done
  );
endinterface

// File: rtl/pi_alu_sequencer.sv
// pi_alu_sequencer
// Control stage ahead of the motion-control ALU. Each go pulse runs one PI update:
// paired IR-sensor A2D reads -> weighted error -> decimated integrator -> P/I terms ->
// right/left motor duties. Selects and op flags are Moore outputs of the state; results are
// captured from the ALU dst at the final clock of each state.
// Ports:
//   clk  : system clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : pi_alu_sequencer_if.master (go, A2D handshake, ALU selects/flags/dst, results, done)
// Parameters: NUM_PAIRS (1..3), MULT_CYC (>=1), INT_DEC (>=1)
// Optional feature macro: INTGRL_CLR_EN (intgrl_clr input clears intgrl and decimation count
// while idle; a clear takes priority over a simultaneous go).

module pi_alu_sequencer #(
  parameter int unsigned NUM_PAIRS = 3,
  parameter int unsigned MULT_CYC  = 2,
  parameter int unsigned INT_DEC   = 4
) (
  input logic                clk,
  input logic                rst,
  pi_alu_sequencer_if.master bus
);

  localparam int unsigned McW  = (MULT_CYC > 1) ? $clog2(MULT_CYC) : 1;
  localparam int unsigned DecW = (INT_DEC > 1) ? $clog2(INT_DEC) : 1;

  // ALU operand select codes
  localparam logic [2:0] S1Accum = 3'd0, S1Iterm = 3'd1, S1Error = 3'd2, S1ErrSh = 3'd3,
                         S1Fwd   = 3'd4;
  localparam logic [2:0] S0A2d   = 3'd0, S0Intgrl = 3'd1, S0Icomp = 3'd2, S0Pcomp = 3'd3,
                         S0Pterm = 3'd4;
  // Any code above 4 is undecoded by the ALU and presents zero on src0
  localparam logic [2:0] S0Zero  = 3'd5;

  typedef enum logic [3:0] {
    StIdle, StClr, StReqE, StAddE, StReqO, StSubO, StErr, StIntg,
    StIcomp, StPcomp, StRht1, StRht2, StLft1, StLft2
  } state_e;

  state_e           r_state, w_state_d;
  logic [1:0]       r_pair;
  logic [McW-1:0]   r_mcnt;
  logic [DecW-1:0]  r_dec;
  logic [15:0]      r_accum, r_pcomp;
  logic [11:0]      r_error, r_intgrl, r_icomp, r_rht, r_lft;
  logic             r_done;

  logic             w_go, w_mult_last, w_last_pair, w_dec_last;
  logic             w_req;
  logic [2:0]       w_chnl, w_src1sel, w_src0sel;
  logic             w_multiply, w_sub, w_mult2, w_mult4, w_saturate;

  assign w_mult_last = (r_mcnt == McW'(MULT_CYC - 1));
  assign w_last_pair = (r_pair == 2'(NUM_PAIRS - 1));
  assign w_dec_last  = (r_dec == DecW'(INT_DEC - 1));

`ifdef INTGRL_CLR_EN
  assign w_go = bus.go & ~bus.intgrl_clr;
`else
  assign w_go = bus.go;
`endif

  always_comb begin
    w_state_d  = r_state;
    w_req      = 1'b0;
    w_chnl     = 3'd0;
    w_src1sel  = 3'd0;
    w_src0sel  = 3'd0;
    w_multiply = 1'b0;
    w_sub      = 1'b0;
    w_mult2    = 1'b0;
    w_mult4    = 1'b0;
    w_saturate = 1'b0;
    unique case (r_state)
      StIdle:  if (w_go) w_state_d = StClr;
      StClr:   w_state_d = StReqE;
      StReqE: begin
        w_req  = 1'b1;
        w_chnl = {r_pair, 1'b0};
        if (bus.a2d_vld) w_state_d = StAddE;
      end
      StAddE: begin
        w_src1sel = S1Accum;
        w_src0sel = S0A2d;
        w_mult2   = (r_pair == 2'd1);
        w_mult4   = (r_pair == 2'd2);
        w_state_d = StReqO;
      end
      StReqO: begin
        w_req  = 1'b1;
        w_chnl = {r_pair, 1'b1};
        if (bus.a2d_vld) w_state_d = StSubO;
      end
      StSubO: begin
        w_src1sel = S1Accum;
        w_src0sel = S0A2d;
        w_mult2   = (r_pair == 2'd1);
        w_mult4   = (r_pair == 2'd2);
        w_sub     = 1'b1;
        w_state_d = w_last_pair ? StErr : StReqE;
      end
      StErr: begin
        w_src1sel  = S1Accum;
        w_src0sel  = S0Zero;
        w_saturate = 1'b1;
        w_state_d  = w_dec_last ? StIntg : StIcomp;
      end
      StIntg: begin
        w_src1sel  = S1ErrSh;
        w_src0sel  = S0Intgrl;
        w_saturate = 1'b1;
        w_state_d  = StIcomp;
      end
      StIcomp: begin
        w_multiply = 1'b1;
        w_src1sel  = S1Iterm;
        w_src0sel  = S0Intgrl;
        if (w_mult_last) w_state_d = StPcomp;
      end
      StPcomp: begin
        w_multiply = 1'b1;
        w_src1sel  = S1Error;
        w_src0sel  = S0Pterm;
        if (w_mult_last) w_state_d = StRht1;
      end
      StRht1: begin
        w_src1sel = S1Fwd;
        w_src0sel = S0Pcomp;
        w_sub     = 1'b1;
        w_state_d = StRht2;
      end
      StRht2: begin
        w_src1sel  = S1Accum;
        w_src0sel  = S0Icomp;
        w_sub      = 1'b1;
        w_saturate = 1'b1;
        w_state_d  = StLft1;
      end
      StLft1: begin
        w_src1sel = S1Fwd;
        w_src0sel = S0Pcomp;
        w_state_d = StLft2;
      end
      StLft2: begin
        w_src1sel  = S1Accum;
        w_src0sel  = S0Icomp;
        w_saturate = 1'b1;
        w_state_d  = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= StIdle;
      r_pair   <= '0;
      r_mcnt   <= '0;
      r_dec    <= '0;
      r_accum  <= '0;
      r_pcomp  <= '0;
      r_error  <= '0;
      r_intgrl <= '0;
      r_icomp  <= '0;
      r_rht    <= '0;
      r_lft    <= '0;
      r_done   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_done  <= 1'b0;
      case (r_state)
        StIdle: begin
`ifdef INTGRL_CLR_EN
          if (bus.intgrl_clr) begin
            r_intgrl <= '0;
            r_dec    <= '0;
          end
`endif
        end
        StClr: begin
          r_accum <= '0;
          r_pair  <= '0;
        end
        StAddE:  r_accum <= bus.dst;
        StSubO: begin
          r_accum <= bus.dst;
          if (!w_last_pair) r_pair <= r_pair + 2'd1;
        end
        StErr:   r_error  <= bus.dst[11:0];
        StIntg:  r_intgrl <= bus.dst[11:0];
        StIcomp: begin
          r_mcnt <= w_mult_last ? '0 : r_mcnt + 1'b1;
          if (w_mult_last) r_icomp <= bus.dst[11:0];
        end
        StPcomp: begin
          r_mcnt <= w_mult_last ? '0 : r_mcnt + 1'b1;
          if (w_mult_last) r_pcomp <= bus.dst;
        end
        StRht1:  r_accum <= bus.dst;
        StRht2:  r_rht   <= bus.dst[11:0];
        StLft1:  r_accum <= bus.dst;
        StLft2: begin
          r_lft  <= bus.dst[11:0];
          // Registered so done coincides with the new lft value
          r_done <= 1'b1;
          r_dec  <= w_dec_last ? '0 : r_dec + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a2d_req  = w_req;
  assign bus.a2d_chnl = w_chnl;
  assign bus.src1sel  = w_src1sel;
  assign bus.src0sel  = w_src0sel;
  assign bus.multiply = w_multiply;
  assign bus.sub      = w_sub;
  assign bus.mult2    = w_mult2;
  assign bus.mult4    = w_mult4;
  assign bus.saturate = w_saturate;
  assign bus.accum    = r_accum;
  assign bus.pcomp    = r_pcomp;
  assign bus.error    = r_error;
  assign bus.intgrl   = r_intgrl;
  assign bus.icomp    = r_icomp;
  assign bus.rht      = r_rht;
  assign bus.lft      = r_lft;
  assign bus.done     = r_done;

endmodule

// File: tb/tb_pi_alu_sequencer.sv
// tb_pi_alu_sequencer
// Bench for pi_alu_sequencer with a behavioural ALU and A2D responder. Expected results
// are queued when each update is launched and checked by a monitor whenever done pulses.
// ALU model: src1/src0 sign/zero-extended to 17 bits, src0 scaled by mult2/mult4,
// add or subtract, optional saturation to signed 12 bits, multiply = (s1[14:0]*s0[14:0])>>12.

`timescale 1ns/1ps

module tb_pi_alu_sequencer;

  localparam logic [13:0] PTERM = 14'h3680;
  localparam logic [11:0] ITERM = 12'h500;
  localparam logic [11:0] FWD   = 12'h300;

  typedef struct packed {
    logic [11:0] error;
    logic [11:0] intgrl;
    logic [11:0] icomp;
    logic [15:0] pcomp;
    logic [11:0] rht;
    logic [11:0] lft;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pi_alu_sequencer_if bus ();

  pi_alu_sequencer #(
    .NUM_PAIRS(3),
    .MULT_CYC (2),
    .INT_DEC  (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  exp_t        exp_q[$];
  logic [2:0]  chnl_log[$];
  logic [11:0] res_even = '0;
  logic [11:0] res_odd  = '0;
  int          a2d_delay = 0;
  bit          stray_vld = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // ALU model
  logic signed [16:0] alu_s1, alu_s0, alu_sum;
  logic signed [29:0] alu_prod;
  always_comb begin
    alu_s1 = '0;
    case (bus.src1sel)
      3'd0:    alu_s1 = {bus.accum[15], bus.accum};
      3'd1:    alu_s1 = {5'd0, ITERM};
      3'd2:    alu_s1 = {{5{bus.error[11]}}, bus.error};
      3'd3:    alu_s1 = {{9{bus.error[11]}}, bus.error[11:4]};
      3'd4:    alu_s1 = {5'd0, FWD};
      default: alu_s1 = '0;
    endcase
    alu_s0 = '0;
    case (bus.src0sel)
      3'd0:    alu_s0 = {5'd0, bus.a2d_res};
      3'd1:    alu_s0 = {{5{bus.intgrl[11]}}, bus.intgrl};
      3'd2:    alu_s0 = {{5{bus.icomp[11]}}, bus.icomp};
      3'd3:    alu_s0 = {bus.pcomp[15], bus.pcomp};
      3'd4:    alu_s0 = {3'd0, PTERM};
      default: alu_s0 = '0;
    endcase
    if (bus.mult4)      alu_s0 = alu_s0 <<< 2;
    else if (bus.mult2) alu_s0 = alu_s0 <<< 1;
    alu_sum  = bus.sub ? alu_s1 - alu_s0 : alu_s1 + alu_s0;
    alu_prod = $signed(alu_s1[14:0]) * $signed(alu_s0[14:0]);
    bus.dst  = alu_sum[15:0];
    if (bus.multiply) begin
      bus.dst = alu_prod[27:12];
    end else if (bus.saturate) begin
      if (alu_sum > 17'sd2047)       bus.dst = 16'h07FF;
      else if (alu_sum < -17'sd2048) bus.dst = 16'hF800;
    end
  end

  // A2D responder: answers each request after a2d_delay clocks, logs the channel
  initial begin : a2d_model
    logic [2:0] ch;
    bit         stable;
    bus.a2d_vld = 1'b0;
    bus.a2d_res = '0;
    forever begin
      @(negedge clk);
      bus.a2d_vld = 1'b0;
      if (stray_vld && bus.a2d_req !== 1'b1) begin
        bus.a2d_res = 12'hABC;
        bus.a2d_vld = 1'b1;
      end else if (bus.a2d_req === 1'b1) begin
        ch     = bus.a2d_chnl;
        stable = 1'b1;
        for (int k = 0; k < a2d_delay; k++) begin
          @(negedge clk);
          if (bus.a2d_req !== 1'b1 || bus.a2d_chnl !== ch) stable = 1'b0;
        end
        if (a2d_delay > 0) chk("req_chnl_stable", 128'(stable), 128'(1));
        bus.a2d_res = ch[0] ? res_odd : res_even;
        bus.a2d_vld = 1'b1;
        chnl_log.push_back(ch);
      end
    end
  end

  // Monitor: pops one expectation per done pulse
  initial begin : monitor
    exp_t e;
    logic prev_done;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        chk("done_pulse_width", 128'(prev_done), 128'(0));
        chk("pending_expect", 128'(exp_q.size()), 128'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("error",  128'(bus.error),  128'(e.error));
          chk("intgrl", 128'(bus.intgrl), 128'(e.intgrl));
          chk("icomp",  128'(bus.icomp),  128'(e.icomp));
          chk("pcomp",  128'(bus.pcomp),  128'(e.pcomp));
          chk("rht",    128'(bus.rht),    128'(e.rht));
          chk("lft",    128'(bus.lft),    128'(e.lft));
        end
      end
      prev_done = bus.done;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_zero(input string name);
    chk(name, 128'({bus.accum, bus.pcomp, bus.error, bus.intgrl, bus.icomp, bus.rht, bus.lft,
                    bus.done, bus.a2d_req, bus.a2d_chnl, bus.src1sel, bus.src0sel,
                    bus.multiply, bus.sub, bus.mult2, bus.mult4, bus.saturate}), 128'(0));
  endtask

  task automatic do_reset();
    bus.go = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_go();
    bus.go = 1'b1;
    @(negedge clk);
    bus.go = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) seen = 1'b1;
    end
    chk("done_within_budget", 128'(seen), 128'(1));
    if (!seen) exp_q.delete();
    @(negedge clk);  // let the monitor consume this done first
  endtask

  task automatic run(input logic [11:0] ev, input logic [11:0] od, input int dly,
                     input exp_t e, input bit extra_go);
    res_even  = ev;
    res_odd   = od;
    a2d_delay = dly;
    chnl_log.delete();
    exp_q.push_back(e);
    @(negedge clk);
    pulse_go();
    if (extra_go) begin
      repeat (3) @(negedge clk);
      pulse_go();
    end
    wait_done(1000);
    chk("chnl_count", 128'(chnl_log.size()), 128'(6));
    for (int i = 0; i < chnl_log.size() && i < 6; i++) chk("chnl_order", 128'(chnl_log[i]), 128'(i));
  endtask

  exp_t e_flat, e_t2, e_t3, e_sat;
  bit   hit;

  initial begin : stimulus
    // error, intgrl, icomp, pcomp, rht, lft
    e_flat = '{12'h000, 12'h000, 12'h000, 16'h0000, 12'h300, 12'h300};
    e_t2   = '{12'h070, 12'h000, 12'h000, 16'h017D, 12'h183, 12'h47D};
    e_t3   = '{12'h070, 12'h007, 12'h002, 16'h017D, 12'h181, 12'h47F};
    e_sat  = '{12'h7FF, 12'h000, 12'h000, 16'h1B3C, 12'h800, 12'h7FF};
    bus.go = 1'b0;
`ifdef INTGRL_CLR_EN
    bus.intgrl_clr = 1'b0;
`endif
    do_reset();
    check_zero("reset_state");

    // Stray a2d_vld in idle must do nothing
    stray_vld = 1'b1;
    repeat (3) @(negedge clk);
    stray_vld = 1'b0;
    @(negedge clk);
    check_zero("stray_vld_idle");

    // 1: balanced sensors
    run(12'h100, 12'h100, 0, e_flat, 1'b0);

    // 2: even channels only, plus a go while busy that must be ignored
    do_reset();
    run(12'h010, 12'h000, 0, e_t2, 1'b1);
    repeat (3) @(negedge clk);
    chk("go_not_queued", 128'(bus.a2d_req), 128'(0));

    // 3: integrator updates only on the 4th update
    do_reset();
    for (int i = 0; i < 3; i++) run(12'h010, 12'h000, 0, e_t2, 1'b0);
    run(12'h010, 12'h000, 0, e_t3, 1'b0);
`ifdef INTGRL_CLR_EN
    bus.intgrl_clr = 1'b1;
    @(negedge clk);
    bus.intgrl_clr = 1'b0;
    chk("intgrl_clr", 128'(bus.intgrl), 128'(0));
`endif

    // 4: slow A2D gives identical results
    do_reset();
    run(12'h010, 12'h000, 20, e_t2, 1'b0);

    // 5: reset in SUB_O of pair 1, then a fresh-equivalent run
    do_reset();
    run(12'h010, 12'h000, 0, e_t2, 1'b0);
    a2d_delay = 0;
    pulse_go();
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(posedge clk);
      #1;
      if (bus.sub === 1'b1 && bus.mult2 === 1'b1) hit = 1'b1;
    end
    chk("reached_sub_o_pair1", 128'(hit), 128'(1));
    rst = 1'b1;
    #1;
    check_zero("mid_update_reset");
    @(negedge clk);
    rst = 1'b0;
    run(12'h010, 12'h000, 0, e_t2, 1'b0);

    // 6: saturation
    do_reset();
    run(12'hFFF, 12'h000, 0, e_sat, 1'b0);

    repeat (5) @(negedge clk);
    chk("all_expect_consumed", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
